mac_t_frame_loader: RTL and testbench
=====================================

MAC_T_FRAME_LOADER -- requirements
Module: mac_t_frame_loader

Interface
REQ-001 Parameter MIN_LEN, default 60, minimum frame byte count excluding FCS; shorter frames are zero-padded.
REQ-002 Parameter MAX_LEN, default 1514, maximum frame byte count excluding FCS; longer frames are truncated.
REQ-003 sys_clk  in  1  single clock for all logic.
REQ-004 rst_sys  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  upstream byte valid.
REQ-006 in_ready  out  1  upstream byte accepted when in_valid && in_ready.
REQ-007 in_data  in  8  frame byte, destination MAC first, no preamble, no FCS.
REQ-008 in_sop / in_eop  in  1 each  first / last byte of frame markers.
REQ-009 in_tte  in  1  frame class, sampled with the sop beat; 1 = TTE path, 0 = normal path.
REQ-010 data_fifo_wr, data_fifo_dout[7:0], data_fifo_space[11:0] (in), ptr_fifo_wr, ptr_fifo_dout[15:0], ptr_fifo_full (in)  normal-path FIFO write side.
REQ-011 tdata_fifo_wr, tdata_fifo_dout[7:0], tdata_fifo_space[11:0] (in), tptr_fifo_wr, tptr_fifo_dout[15:0], tptr_fifo_full (in)  TTE-path FIFO write side.
REQ-012 cnt_frame, cnt_trunc, cnt_pad, cnt_err  out  16 each  saturating event counters.

Function
REQ-013 FSM states: IDLE, DATA, PAD, DISC, PTR; one-hot encoding.
REQ-014 IDLE: in_ready=0; on in_valid && in_sop, if selected class space >= MAX_LEN and its ptr FIFO not full, latch class and go to DATA; otherwise stay in IDLE and stall.
REQ-015 IDLE: in_valid && !in_sop -> DISC, increment cnt_err.
REQ-016 DATA: in_ready=1; each accepted byte is written to the latched class data FIFO exactly one cycle later (registered wr/dout); byte counter len[10:0] increments per accepted byte.
REQ-017 DATA: in_sop on a non-first byte is treated as data and increments cnt_err.
REQ-018 DATA: accepted eop byte with len+1 >= MIN_LEN -> PTR; with len+1 < MIN_LEN -> PAD.
REQ-019 DATA: accepted byte that makes len == MAX_LEN without eop -> DISC, increment cnt_trunc; an eop on that same byte -> PTR, no truncation.
REQ-020 PAD: in_ready=0; write one 8'h00 byte per cycle until len == MIN_LEN, then PTR; increment cnt_pad once per padded frame.
REQ-021 DISC: in_ready=1; bytes accepted and dropped, no FIFO writes; on accepted eop go to PTR when the frame was truncated, otherwise IDLE.
REQ-022 PTR: single cycle; write ptr word {5'b0, len[10:0]} to the latched class ptr FIFO, after the last data write; increment cnt_frame; -> IDLE with len cleared.
REQ-023 Ptr word never precedes its final data byte; the last data write and the ptr write occur no earlier than consecutive cycles.
REQ-024 Write strobes of the non-selected class stay 0 throughout a frame.
REQ-025 Counters saturate at 16'hFFFF and never wrap.
REQ-026 Valid low mid-frame inserts idle cycles only; len and state hold.

Reset
REQ-027 rst_sys high at a rising sys_clk edge: state=IDLE, len=0, latched class=0, all wr strobes 0, all dout 0, in_ready 0, all counters 0.
REQ-028 A reset mid-frame abandons the frame: no further data or ptr writes; any partial data already in the FIFO is the system's responsibility.

Verification
REQ-029 100-byte normal frame, space=4095 -> 100 data_fifo_wr pulses, then one ptr_fifo_wr of 16'h0064; cnt_frame=1.
REQ-030 20-byte TTE frame -> 20 tdata bytes + 40 bytes of 8'h00, tptr word 16'h003C; cnt_pad=1; no normal-path writes.
REQ-031 1600-byte frame -> 1514 bytes written, 86 dropped, ptr 16'h05EA; cnt_trunc=1.
REQ-032 sop with data_fifo_space=1000 for 50 cycles, then 2000 -> in_ready 0 and no writes while stalled; frame then completes normally.
REQ-033 Non-sop byte in IDLE followed by bytes up to eop -> all dropped, cnt_err=1, no ptr write.
REQ-034 Reset asserted at byte 30 of a 100-byte frame -> no writes after reset; next frame's ptr reflects only that frame.

Source files
------------

// File: rtl/mac_t_frame_loader.sv
// mac_t_frame_loader: accepts a byte stream of Ethernet frames and writes each
// frame into one of two FIFO pairs (normal or TTE). Frames shorter than MIN_LEN
// are zero-padded, frames longer than MAX_LEN are truncated. A pointer word
// holding the stored length follows the last data byte. All FIFO write-side
// outputs are registered.
module mac_t_frame_loader #(
   parameter int MIN_LEN = 60,
   parameter int MAX_LEN = 1514
) (
   input  logic        sys_clk,
   input  logic        rst_sys,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic        in_tte,
   output logic        data_fifo_wr,
   output logic [7:0]  data_fifo_dout,
   input  logic [11:0] data_fifo_space,
   output logic        ptr_fifo_wr,
   output logic [15:0] ptr_fifo_dout,
   input  logic        ptr_fifo_full,
   output logic        tdata_fifo_wr,
   output logic [7:0]  tdata_fifo_dout,
   input  logic [11:0] tdata_fifo_space,
   output logic        tptr_fifo_wr,
   output logic [15:0] tptr_fifo_dout,
   input  logic        tptr_fifo_full,
   output logic [15:0] cnt_frame,
   output logic [15:0] cnt_trunc,
   output logic [15:0] cnt_pad,
   output logic [15:0] cnt_err
);

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_DATA = 5'b00010,
      S_PAD  = 5'b00100,
      S_DISC = 5'b01000,
      S_PTR  = 5'b10000
   } state_t;

   localparam logic [10:0] L_MIN   = MIN_LEN[10:0];
   localparam logic [10:0] L_MAX   = MAX_LEN[10:0];
   localparam logic [11:0] L_SPACE = MAX_LEN[11:0];

   state_t      r_state, w_nxt;
   logic [10:0] r_len, w_len_nxt, w_len_inc;
   logic        r_cls, w_cls_nxt;     // 1 = TTE path
   logic        r_trunc, w_trunc_nxt; // current frame hit MAX_LEN
   logic        r_wr, w_wr;
   logic [7:0]  r_dout, w_dout;
   logic        r_pwr, w_pwr;
   logic [15:0] r_pdout;
   logic [15:0] r_cnt_frame, r_cnt_trunc, r_cnt_pad, r_cnt_err;
   logic        w_inc_frame, w_inc_trunc, w_inc_pad, w_inc_err;
   logic        w_acc, w_room;

   assign in_ready  = (r_state == S_DATA) || (r_state == S_DISC);
   assign w_acc     = in_valid && in_ready;
   assign w_len_inc = r_len + 11'd1;
   // a whole worst-case frame must fit before a frame is started
   assign w_room    = in_tte ? ((tdata_fifo_space >= L_SPACE) && !tptr_fifo_full)
                             : ((data_fifo_space  >= L_SPACE) && !ptr_fifo_full);

   // next-state, write intents and counter events
   always_comb begin
      w_nxt       = r_state;
      w_len_nxt   = r_len;
      w_cls_nxt   = r_cls;
      w_trunc_nxt = r_trunc;
      w_wr        = 1'b0;
      w_dout      = 8'h00;
      w_pwr       = 1'b0;
      w_inc_frame = 1'b0;
      w_inc_trunc = 1'b0;
      w_inc_pad   = 1'b0;
      w_inc_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               if (!in_sop) begin
                  w_nxt     = S_DISC;
                  w_inc_err = 1'b1;
               end else if (w_room) begin
                  w_cls_nxt = in_tte;
                  w_nxt     = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_acc) begin
               w_wr      = 1'b1;
               w_dout    = in_data;
               w_len_nxt = w_len_inc;
               if (in_sop && (r_len != 11'd0)) w_inc_err = 1'b1;
               if (in_eop) begin
                  if (w_len_inc >= L_MIN) begin
                     w_nxt = S_PTR;
                  end else begin
                     w_nxt     = S_PAD;
                     w_inc_pad = 1'b1;
                  end
               end else if (w_len_inc == L_MAX) begin
                  w_nxt       = S_DISC;
                  w_trunc_nxt = 1'b1;
                  w_inc_trunc = 1'b1;
               end
            end
         end
         S_PAD: begin
            w_wr      = 1'b1;
            w_len_nxt = w_len_inc;
            if (w_len_inc == L_MIN) w_nxt = S_PTR;
         end
         S_DISC: begin
            if (w_acc && in_eop) w_nxt = r_trunc ? S_PTR : S_IDLE;
         end
         S_PTR: begin
            w_pwr       = 1'b1;
            w_inc_frame = 1'b1;
            w_len_nxt   = 11'd0;
            w_trunc_nxt = 1'b0;
            w_nxt       = S_IDLE;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   // state, registered FIFO writes and saturating counters
   always_ff @(posedge sys_clk) begin
      if (rst_sys) begin
         r_state     <= S_IDLE;
         r_len       <= 11'd0;
         r_cls       <= 1'b0;
         r_trunc     <= 1'b0;
         r_wr        <= 1'b0;
         r_dout      <= 8'h00;
         r_pwr       <= 1'b0;
         r_pdout     <= 16'h0000;
         r_cnt_frame <= 16'h0000;
         r_cnt_trunc <= 16'h0000;
         r_cnt_pad   <= 16'h0000;
         r_cnt_err   <= 16'h0000;
      end else begin
         r_state <= w_nxt;
         r_len   <= w_len_nxt;
         r_cls   <= w_cls_nxt;
         r_trunc <= w_trunc_nxt;
         r_wr    <= w_wr;
         r_dout  <= w_dout;
         r_pwr   <= w_pwr;
         if (w_pwr) r_pdout <= {5'b0, r_len};
         if (w_inc_frame && (r_cnt_frame != 16'hFFFF)) r_cnt_frame <= r_cnt_frame + 16'd1;
         if (w_inc_trunc && (r_cnt_trunc != 16'hFFFF)) r_cnt_trunc <= r_cnt_trunc + 16'd1;
         if (w_inc_pad   && (r_cnt_pad   != 16'hFFFF)) r_cnt_pad   <= r_cnt_pad   + 16'd1;
         if (w_inc_err   && (r_cnt_err   != 16'hFFFF)) r_cnt_err   <= r_cnt_err   + 16'd1;
      end
   end

   // r_cls is stable from frame start until the cycle after the ptr write
   assign data_fifo_wr    = r_wr  & ~r_cls;
   assign tdata_fifo_wr   = r_wr  &  r_cls;
   assign ptr_fifo_wr     = r_pwr & ~r_cls;
   assign tptr_fifo_wr    = r_pwr &  r_cls;
   assign data_fifo_dout  = r_dout;
   assign tdata_fifo_dout = r_dout;
   assign ptr_fifo_dout   = r_pdout;
   assign tptr_fifo_dout  = r_pdout;
   assign cnt_frame       = r_cnt_frame;
   assign cnt_trunc       = r_cnt_trunc;
   assign cnt_pad         = r_cnt_pad;
   assign cnt_err         = r_cnt_err;

endmodule

// File: tb/tb_mac_t_frame_loader.sv
// Bench for mac_t_frame_loader: table of directed frames, hand-written stall
// and reset sequences, then random frames checked against a frame-level model.
module tb_mac_t_frame_loader;

   localparam int MIN_LEN = 60;
   localparam int MAX_LEN = 1514;

   logic        sys_clk = 1'b0;
   logic        rst_sys;
   logic        in_valid, in_ready, in_sop, in_eop, in_tte;
   logic [7:0]  in_data;
   logic        data_fifo_wr, ptr_fifo_wr, tdata_fifo_wr, tptr_fifo_wr;
   logic [7:0]  data_fifo_dout, tdata_fifo_dout;
   logic [15:0] ptr_fifo_dout, tptr_fifo_dout;
   logic [11:0] data_fifo_space, tdata_fifo_space;
   logic        ptr_fifo_full, tptr_fifo_full;
   logic [15:0] cnt_frame, cnt_trunc, cnt_pad, cnt_err;

   mac_t_frame_loader #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
      .sys_clk(sys_clk), .rst_sys(rst_sys),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sop(in_sop), .in_eop(in_eop), .in_tte(in_tte),
      .data_fifo_wr(data_fifo_wr), .data_fifo_dout(data_fifo_dout),
      .data_fifo_space(data_fifo_space),
      .ptr_fifo_wr(ptr_fifo_wr), .ptr_fifo_dout(ptr_fifo_dout),
      .ptr_fifo_full(ptr_fifo_full),
      .tdata_fifo_wr(tdata_fifo_wr), .tdata_fifo_dout(tdata_fifo_dout),
      .tdata_fifo_space(tdata_fifo_space),
      .tptr_fifo_wr(tptr_fifo_wr), .tptr_fifo_dout(tptr_fifo_dout),
      .tptr_fifo_full(tptr_fifo_full),
      .cnt_frame(cnt_frame), .cnt_trunc(cnt_trunc), .cnt_pad(cnt_pad), .cnt_err(cnt_err)
   );

   always #5 sys_clk = ~sys_clk;

   int errs = 0, checks = 0;
   int cyc = 0, last_d = 0, last_p = 0;
   bit gaps = 1'b0;
   logic [7:0]  dq[$], tq[$], sent[$];
   logic [15:0] pq[$], tpq[$];
   int m_frame = 0, m_trunc = 0, m_pad = 0, m_err = 0;

   typedef struct {
      int          n;
      bit          tte;
      bit          sop;
      int          midsop;
      int          exp_n;
      bit          has_ptr;
      logic [15:0] exp_ptr;
   } vec_t;
   vec_t vt[11];

   always @(posedge sys_clk) cyc++;

   // capture every FIFO write mid-cycle
   always @(negedge sys_clk) begin
      if (data_fifo_wr)  begin dq.push_back(data_fifo_dout);   last_d = cyc; end
      if (tdata_fifo_wr) begin tq.push_back(tdata_fifo_dout);  last_d = cyc; end
      if (ptr_fifo_wr)   begin pq.push_back(ptr_fifo_dout);    last_p = cyc; end
      if (tptr_fifo_wr)  begin tpq.push_back(tptr_fifo_dout);  last_p = cyc; end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic put_byte(input logic [7:0] d, input logic sop, input logic eop, input logic tte);
      int waitc = 0;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
         in_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge sys_clk);
         #1;
      end
      in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_tte = tte;
      @(negedge sys_clk);
      while (!in_ready && waitc < 200) begin @(negedge sys_clk); waitc++; end
      if (!in_ready) begin
         checks++; errs++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
      end
      @(posedge sys_clk); #1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   task automatic send_frame(input int n, input bit tte, input bit sop, input int mid);
      logic [7:0] b;
      sent.delete();
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         sent.push_back(b);
         put_byte(b, (i == 0) ? sop : (mid != 0 && i == mid), i == n - 1, tte);
      end
      repeat (MIN_LEN + 8) @(negedge sys_clk);
   endtask

   // model the frame from its byte list and compare against captured writes
   task automatic check_frame(input int n, input bit tte, input bit sop, input int mid,
                              input int exp_n, input bit has_ptr, input logic [15:0] exp_ptr);
      logic [7:0] ex[$];
      int k, mism;
      ex.delete();
      if (sop) begin
         k = (n > MAX_LEN) ? MAX_LEN : n;
         for (int i = 0; i < k; i++) ex.push_back(sent[i]);
         while (ex.size() < MIN_LEN) ex.push_back(8'h00);
         m_frame++;
         if (n > MAX_LEN) m_trunc++;
         if (n < MIN_LEN) m_pad++;
         if (mid != 0 && mid < k) m_err++;
      end else begin
         m_err++;
      end
      mism = 0;
      if (tte) begin
         chk("nbytes", tq.size(), exp_n);
         for (int i = 0; i < ex.size() && i < tq.size(); i++) if (tq[i] !== ex[i]) mism++;
         chk("other_path_wr", dq.size() + pq.size(), 0);
         chk("ptr_count", tpq.size(), has_ptr);
         if (tpq.size() > 0) chk("ptr_word", tpq[0], exp_ptr);
      end else begin
         chk("nbytes", dq.size(), exp_n);
         for (int i = 0; i < ex.size() && i < dq.size(); i++) if (dq[i] !== ex[i]) mism++;
         chk("other_path_wr", tq.size() + tpq.size(), 0);
         chk("ptr_count", pq.size(), has_ptr);
         if (pq.size() > 0) chk("ptr_word", pq[0], exp_ptr);
      end
      chk("byte_mismatches", mism, 0);
      if (has_ptr) chk("ptr_after_data", last_p > last_d, 1);
      chk("cnt_frame", cnt_frame, m_frame);
      chk("cnt_trunc", cnt_trunc, m_trunc);
      chk("cnt_pad",   cnt_pad,   m_pad);
      chk("cnt_err",   cnt_err,   m_err);
      dq.delete(); tq.delete(); pq.delete(); tpq.delete();
   endtask

   initial begin
      int stall_bad, stall_wr, ns, n, mid, en;
      bit tte, sop;

      vt[0]  = '{100,  1'b0, 1'b1, 0, 100,  1'b1, 16'h0064};
      vt[1]  = '{20,   1'b1, 1'b1, 0, 60,   1'b1, 16'h003C};
      vt[2]  = '{1600, 1'b0, 1'b1, 0, 1514, 1'b1, 16'h05EA};
      vt[3]  = '{60,   1'b1, 1'b1, 0, 60,   1'b1, 16'h003C};
      vt[4]  = '{59,   1'b0, 1'b1, 0, 60,   1'b1, 16'h003C};
      vt[5]  = '{61,   1'b0, 1'b1, 0, 61,   1'b1, 16'h003D};
      vt[6]  = '{1514, 1'b1, 1'b1, 0, 1514, 1'b1, 16'h05EA};
      vt[7]  = '{1515, 1'b0, 1'b1, 0, 1514, 1'b1, 16'h05EA};
      vt[8]  = '{1,    1'b0, 1'b1, 0, 60,   1'b1, 16'h003C};
      vt[9]  = '{10,   1'b0, 1'b0, 0, 0,    1'b0, 16'h0000};
      vt[10] = '{30,   1'b1, 1'b1, 5, 60,   1'b1, 16'h003C};

      rst_sys = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sop = 1'b0; in_eop = 1'b0; in_tte = 1'b0;
      data_fifo_space = 12'd4095; tdata_fifo_space = 12'd4095;
      ptr_fifo_full = 1'b0; tptr_fifo_full = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr", {data_fifo_wr, ptr_fifo_wr, tdata_fifo_wr, tptr_fifo_wr}, 0);
      chk("rst_dout", {data_fifo_dout, tdata_fifo_dout, ptr_fifo_dout}, 0);
      chk("rst_counters", {cnt_frame, cnt_trunc} | {cnt_pad, cnt_err}, 0);
      @(posedge sys_clk); #1; rst_sys = 1'b0;

      // directed table
      for (int v = 0; v < 11; v++) begin
         send_frame(vt[v].n, vt[v].tte, vt[v].sop, vt[v].midsop);
         check_frame(vt[v].n, vt[v].tte, vt[v].sop, vt[v].midsop,
                     vt[v].exp_n, vt[v].has_ptr, vt[v].exp_ptr);
      end

      // start stalls while space is short, then completes once space appears
      data_fifo_space = 12'd1000;
      stall_bad = 0; stall_wr = 0;
      fork
         send_frame(40, 1'b0, 1'b1, 0);
         begin
            repeat (50) @(negedge sys_clk) if (in_ready) stall_bad++;
            stall_wr = dq.size() + pq.size() + tq.size() + tpq.size();
            data_fifo_space = 12'd2000;
         end
      join
      chk("stall_ready", stall_bad, 0);
      chk("stall_writes", stall_wr, 0);
      check_frame(40, 1'b0, 1'b1, 0, 60, 1'b1, 16'h003C);
      data_fifo_space = 12'd4095;

      // reset at byte 30 of a 100-byte frame
      for (int i = 0; i < 30; i++) put_byte(8'(i + 1), i == 0, 1'b0, 1'b0);
      rst_sys = 1'b1;
      @(posedge sys_clk); #1;
      rst_sys = 1'b0;
      @(negedge sys_clk);
      ns = dq.size();
      repeat (MIN_LEN + 10) @(negedge sys_clk);
      chk("rst_no_writes", dq.size() - ns + pq.size() + tq.size() + tpq.size(), 0);
      chk("rst_cnt_frame", cnt_frame, 0);
      m_frame = 0; m_trunc = 0; m_pad = 0; m_err = 0;
      dq.delete(); tq.delete(); pq.delete(); tpq.delete();
      send_frame(70, 1'b0, 1'b1, 0);
      check_frame(70, 1'b0, 1'b1, 0, 70, 1'b1, 16'h0046);

      // random frames with valid gaps
      gaps = 1'b1;
      for (int r = 0; r < 24; r++) begin
         n   = ($urandom_range(0, 7) == 0) ? $urandom_range(1400, 1600) : $urandom_range(1, 150);
         tte = 1'($urandom);
         sop = ($urandom_range(0, 9) != 0);
         mid = (sop && n > 3 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
         en  = sop ? ((n > MAX_LEN) ? MAX_LEN : ((n < MIN_LEN) ? MIN_LEN : n)) : 0;
         send_frame(n, tte, sop, mid);
         check_frame(n, tte, sop, mid, en, sop, 16'(en));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
